// File: rtl/msix_pkg.sv
// Shared types and default parameters for the MSI-X interrupt monitor.
// The table entry struct is sized for the default widths.
package msix_pkg;

  localparam int unsigned MSIX_NUM_VEC_DEF   = 8;
  localparam int unsigned MSIX_ADDR_W_DEF    = 64;
  localparam int unsigned MSIX_DATA_W_DEF    = 32;
  localparam int unsigned MSIX_EVT_DEPTH_DEF = 4;
  localparam int unsigned MSIX_CNT_W_DEF     = 8;

  localparam int unsigned MSIX_VEC_ID_W = $clog2(MSIX_NUM_VEC_DEF);

  typedef logic [MSIX_VEC_ID_W-1:0] vec_id_t;

  // Narrower ADDR_W/DATA_W instances zero-extend into these fields.
  typedef struct packed {
    logic                       valid;
    logic                       mask;
    logic [MSIX_ADDR_W_DEF-1:0] addr;
    logic [MSIX_DATA_W_DEF-1:0] data;
  } msix_vec_t;

  typedef enum logic [1:0] {
    HIT_NONE,
    HIT_ERR,
    HIT_MASKED,
    HIT_DELIVER
  } hit_kind_e;

endpackage

// File: rtl/msix_evt_fifo.sv
// Synchronous event FIFO with simultaneous push/pop and a drop strobe
// for a push that finds the FIFO full without a same-cycle pop.
module msix_evt_fifo #(
  parameter int unsigned DEPTH = 4,
  parameter int unsigned WIDTH = 3
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             push,
  input  logic [WIDTH-1:0] push_data,
  input  logic             pop,
  output logic [WIDTH-1:0] pop_data,
  output logic             full,
  output logic             empty,
  output logic             drop
);

  localparam int unsigned AW = $clog2(DEPTH);

  logic [WIDTH-1:0] mem_q [DEPTH];
  logic [WIDTH-1:0] mem_d [DEPTH];
  logic [AW:0]      wr_ptr_q, wr_ptr_d;
  logic [AW:0]      rd_ptr_q, rd_ptr_d;
  logic             push_ok, pop_ok;

  always_comb begin
    empty = (wr_ptr_q == rd_ptr_q);
    full  = (wr_ptr_q[AW] != rd_ptr_q[AW]) &&
            (wr_ptr_q[AW-1:0] == rd_ptr_q[AW-1:0]);
    pop_ok  = pop && !empty;
    // A pop in the same cycle frees the slot, so a full push is accepted.
    push_ok = push && (!full || pop_ok);
    drop    = push && full && !pop_ok;
    pop_data = mem_q[rd_ptr_q[AW-1:0]];

    mem_d    = mem_q;
    wr_ptr_d = wr_ptr_q;
    rd_ptr_d = rd_ptr_q;
    if (push_ok) begin
      mem_d[wr_ptr_q[AW-1:0]] = push_data;
      wr_ptr_d = wr_ptr_q + (AW+1)'(1);
    end
    if (pop_ok) begin
      rd_ptr_d = rd_ptr_q + (AW+1)'(1);
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      for (int unsigned i = 0; i < DEPTH; i++) begin
        mem_q[i] <= '0;
      end
    end else begin
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
      mem_q    <= mem_d;
    end
  end

endmodule

// File: rtl/msix_intr_monitor.sv
// Snoops host DW writes against an MSI-X vector table; tracks pending,
// PBA and hit counts per vector and queues delivered vector IDs.
module msix_intr_monitor
  import msix_pkg::*;
#(
  parameter  int unsigned NUM_VEC   = MSIX_NUM_VEC_DEF,
  parameter  int unsigned ADDR_W    = MSIX_ADDR_W_DEF,
  parameter  int unsigned DATA_W    = MSIX_DATA_W_DEF,
  parameter  int unsigned EVT_DEPTH = MSIX_EVT_DEPTH_DEF,
  parameter  int unsigned CNT_W     = MSIX_CNT_W_DEF,
  localparam int unsigned IDX_W     = (NUM_VEC > 1) ? $clog2(NUM_VEC) : 1
) (
  input  logic               clk,
  input  logic               rst,
  input  logic               wr_valid,
  input  logic [ADDR_W-1:0]  wr_addr,
  input  logic [DATA_W-1:0]  wr_data,
  input  logic               cfg_we,
  input  logic [IDX_W-1:0]   cfg_idx,
  input  logic               cfg_valid,
  input  logic               cfg_mask,
  input  logic [ADDR_W-1:0]  cfg_addr,
  input  logic [DATA_W-1:0]  cfg_data,
  input  logic [NUM_VEC-1:0] clr_vec,
  output logic [NUM_VEC-1:0] intr_pending,
  output logic               intr_any,
  output logic [NUM_VEC-1:0] pba,
  output logic               evt_valid,
  output logic [IDX_W-1:0]   evt_id,
  input  logic               evt_ready,
  output logic               evt_overflow,
  output logic               data_err,
  output logic [IDX_W-1:0]   data_err_id,
  input  logic [IDX_W-1:0]   cnt_sel,
  output logic [CNT_W-1:0]   cnt_val
);

  msix_vec_t          tbl_q [NUM_VEC];
  msix_vec_t          tbl_d [NUM_VEC];
  logic [CNT_W-1:0]   cnt_q [NUM_VEC];
  logic [CNT_W-1:0]   cnt_d [NUM_VEC];
  logic [NUM_VEC-1:0] pend_q, pend_d;
  logic [NUM_VEC-1:0] pba_q, pba_d;
  logic               data_err_q, data_err_d;
  logic [IDX_W-1:0]   data_err_id_q, data_err_id_d;
  logic               ovf_q, ovf_d;

  logic               hit_found;
  logic [IDX_W-1:0]   hit_idx;
  hit_kind_e          hit_kind;
  logic               rp_found;
  logic [IDX_W-1:0]   rp_idx;
  logic               do_replay;
  logic               push;
  logic [IDX_W-1:0]   push_id;
  logic               fifo_full, fifo_empty, fifo_drop;

  // Lowest-index address hit, using the table before any same-cycle cfg write.
  always_comb begin
    hit_found = 1'b0;
    hit_idx   = '0;
    for (int unsigned i = 0; i < NUM_VEC; i++) begin
      if (!hit_found && wr_valid && tbl_q[i].valid &&
          tbl_q[i].addr == MSIX_ADDR_W_DEF'(wr_addr)) begin
        hit_found = 1'b1;
        hit_idx   = IDX_W'(i);
      end
    end
    hit_kind = HIT_NONE;
    if (hit_found) begin
      if (tbl_q[hit_idx].data != MSIX_DATA_W_DEF'(wr_data)) begin
        hit_kind = HIT_ERR;
      end else if (tbl_q[hit_idx].mask) begin
        hit_kind = HIT_MASKED;
      end else begin
        hit_kind = HIT_DELIVER;
      end
    end
  end

  always_comb begin
    rp_found = 1'b0;
    rp_idx   = '0;
    for (int unsigned i = 0; i < NUM_VEC; i++) begin
      if (!rp_found && pba_q[i] && !tbl_q[i].mask && tbl_q[i].valid) begin
        rp_found = 1'b1;
        rp_idx   = IDX_W'(i);
      end
    end
    do_replay = rp_found && (hit_kind != HIT_DELIVER);
    push      = (hit_kind == HIT_DELIVER) || do_replay;
    push_id   = (hit_kind == HIT_DELIVER) ? hit_idx : rp_idx;
  end

  always_comb begin
    tbl_d         = tbl_q;
    cnt_d         = cnt_q;
    pend_d        = pend_q & ~clr_vec;
    pba_d         = pba_q;
    data_err_d    = data_err_q;
    data_err_id_d = data_err_id_q;
    ovf_d         = ovf_q | fifo_drop;

    case (hit_kind)
      HIT_DELIVER: begin
        pend_d[hit_idx] = 1'b1;
        if (cnt_q[hit_idx] != '1) cnt_d[hit_idx] = cnt_q[hit_idx] + CNT_W'(1);
      end
      HIT_MASKED: begin
        pba_d[hit_idx] = 1'b1;
        if (cnt_q[hit_idx] != '1) cnt_d[hit_idx] = cnt_q[hit_idx] + CNT_W'(1);
      end
      HIT_ERR: begin
        if (!data_err_q) begin
          data_err_d    = 1'b1;
          data_err_id_d = hit_idx;
        end
      end
      default: ;
    endcase

    if (do_replay) begin
      pba_d[rp_idx]  = 1'b0;
      pend_d[rp_idx] = 1'b1;
    end

    if (cfg_we) begin
      tbl_d[cfg_idx] = '{valid: cfg_valid,
                         mask:  cfg_mask,
                         addr:  MSIX_ADDR_W_DEF'(cfg_addr),
                         data:  MSIX_DATA_W_DEF'(cfg_data)};
      if (!cfg_valid) pba_d[cfg_idx] = 1'b0;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      for (int unsigned i = 0; i < NUM_VEC; i++) begin
        tbl_q[i] <= '0;
        cnt_q[i] <= '0;
      end
      pend_q        <= '0;
      pba_q         <= '0;
      data_err_q    <= 1'b0;
      data_err_id_q <= '0;
      ovf_q         <= 1'b0;
    end else begin
      tbl_q         <= tbl_d;
      cnt_q         <= cnt_d;
      pend_q        <= pend_d;
      pba_q         <= pba_d;
      data_err_q    <= data_err_d;
      data_err_id_q <= data_err_id_d;
      ovf_q         <= ovf_d;
    end
  end

  msix_evt_fifo #(
    .DEPTH (EVT_DEPTH),
    .WIDTH (IDX_W)
  ) u_evt_fifo (
    .clk       (clk),
    .rst       (rst),
    .push      (push),
    .push_data (push_id),
    .pop       (evt_ready),
    .pop_data  (evt_id),
    .full      (fifo_full),
    .empty     (fifo_empty),
    .drop      (fifo_drop)
  );

  always_comb begin
    intr_pending = pend_q;
    intr_any     = |pend_q;
    pba          = pba_q;
    evt_valid    = !fifo_empty;
    evt_overflow = ovf_q;
    data_err     = data_err_q;
    data_err_id  = data_err_id_q;
    cnt_val      = '0;
    if (32'(cnt_sel) < NUM_VEC) cnt_val = cnt_q[cnt_sel];
  end

endmodule
